// File: rtl/lc3_operate_sequencer.sv
// lc3_operate_sequencer: multi-cycle fetch/decode/execute control for the LC-3
// operate subset (ADD, AND, NOT). It drives the register-file selects and the ALU
// control, and it keeps pc, ir, the condition codes and the retired-instruction count.
//
// state     | meaning
// S_IDLE    | parked, waiting for run
// S_FETCH   | instruction read outstanding on the memory port
// S_DECODE  | opcode check on the freshly loaded ir
// S_EXECUTE | write-back cycle; nzp and instr_count update on its closing edge
module lc3_operate_sequencer #(
  parameter logic [15:0] PC_RESET = 16'h3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [2:0]  sr1_sel,
  output logic [2:0]  sr2_sel,
  output logic [2:0]  dr_sel,
  output logic        reg_we,
  output logic [1:0]  alu_control,
  output logic [5:0]  alu_imm,
  input  logic [15:0] alu_out,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic [2:0]  nzp,
  output logic        illegal,
  output logic [15:0] instr_count
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DECODE  = 2'd2,
    S_EXECUTE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_instr_count;
  logic [2:0]  r_nzp;
  logic        r_illegal;
  logic        w_legal;
  logic [2:0]  w_nzp_next;

  // Opcode legality and ALU function decoded from the registered instruction
  always_comb begin
    w_legal     = 1'b0;
    alu_control = 2'b00;
    case (r_ir[15:12])
      OP_ADD: begin
        w_legal     = 1'b1;
        alu_control = 2'b01;
      end
      OP_AND: begin
        w_legal     = 1'b1;
        alu_control = 2'b10;
      end
      OP_NOT: begin
        w_legal     = 1'b1;
        alu_control = 2'b11;
      end
      default: begin
        w_legal     = 1'b0;
        alu_control = 2'b00;
      end
    endcase
  end

  // Condition codes derived from the ALU result being written back
  always_comb begin
    if (alu_out[15]) begin
      w_nzp_next = 3'b100;
    end else if (alu_out == 16'h0000) begin
      w_nzp_next = 3'b010;
    end else begin
      w_nzp_next = 3'b001;
    end
  end

  // Next-state selection and per-state handshake/write strobes
  always_comb begin
    w_state_next = r_state;
    mem_rd       = 1'b0;
    reg_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        // Once issued, a fetch is never abandoned, so run is not looked at here.
        mem_rd = 1'b1;
        if (mem_ready) begin
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_state_next = S_EXECUTE;
        end else if (run) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_EXECUTE: begin
        reg_we       = 1'b1;
        w_state_next = run ? S_FETCH : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Architectural registers: pc/ir on fetch completion, illegal on decode, nzp/count on execute
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc          <= PC_RESET;
      r_ir          <= 16'h0000;
      r_nzp         <= 3'b010;
      r_illegal     <= 1'b0;
      r_instr_count <= 16'h0000;
    end else begin
      if ((r_state == S_FETCH) && mem_ready) begin
        r_ir <= mem_rdata;
        r_pc <= r_pc + 16'd1;
      end
      if ((r_state == S_DECODE) && !w_legal) begin
        r_illegal <= 1'b1;
      end
      if (r_state == S_EXECUTE) begin
        r_nzp         <= w_nzp_next;
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign nzp         = r_nzp;
  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

  // NOT is forwarded like the others; the all-ones immediate field is not checked.
  assign sr1_sel = r_ir[8:6];
  assign sr2_sel = r_ir[2:0];
  assign dr_sel  = r_ir[11:9];
  assign alu_imm = r_ir[5:0];

endmodule

// File: tb/tb_lc3_operate_sequencer.sv
// tb_lc3_operate_sequencer: directed program through a wait-state memory, an
// instruction-level reference model checked on every cycle, and literal timeline checks.
module tb_lc3_operate_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [2:0]  sr1_sel, sr2_sel, dr_sel;
  logic        reg_we;
  logic [1:0]  alu_control;
  logic [5:0]  alu_imm;
  logic [15:0] alu_out;
  logic [15:0] ir, pc, instr_count;
  logic [2:0]  nzp;
  logic        illegal;

  // second instance for the pc wrap case
  logic        run_w;
  logic [15:0] mem_addr_w;
  logic        mem_rd_w;
  logic [15:0] mem_rdata_w;
  logic        mem_ready_w;
  logic [2:0]  sr1_sel_w, sr2_sel_w, dr_sel_w;
  logic        reg_we_w;
  logic [1:0]  alu_control_w;
  logic [5:0]  alu_imm_w;
  logic [15:0] alu_out_w;
  logic [15:0] ir_w, pc_w, instr_count_w;
  logic [2:0]  nzp_w;
  logic        illegal_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lc3_operate_sequencer #(.PC_RESET(16'h3000)) u_dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sr1_sel(sr1_sel), .sr2_sel(sr2_sel), .dr_sel(dr_sel), .reg_we(reg_we),
    .alu_control(alu_control), .alu_imm(alu_imm), .alu_out(alu_out),
    .ir(ir), .pc(pc), .nzp(nzp), .illegal(illegal), .instr_count(instr_count)
  );

  lc3_operate_sequencer #(.PC_RESET(16'hFFFF)) u_wrap (
    .clk(clk), .reset_n(reset_n), .run(run_w),
    .mem_addr(mem_addr_w), .mem_rd(mem_rd_w), .mem_rdata(mem_rdata_w), .mem_ready(mem_ready_w),
    .sr1_sel(sr1_sel_w), .sr2_sel(sr2_sel_w), .dr_sel(dr_sel_w), .reg_we(reg_we_w),
    .alu_control(alu_control_w), .alu_imm(alu_imm_w), .alu_out(alu_out_w),
    .ir(ir_w), .pc(pc_w), .nzp(nzp_w), .illegal(illegal_w), .instr_count(instr_count_w)
  );

  // program memory at 0x3000.., per-word wait states and ALU results
  logic [15:0] rom     [16];
  int          waits   [16];
  logic [15:0] alu_tab [16];
  int          wcnt = 0;
  logic        force_ready = 1'b0;
  logic [15:0] prev_pc;

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom[i] = 16'h0000; waits[i] = 0; alu_tab[i] = 16'h0000;
    end
    rom[0] = 16'h1261; alu_tab[0] = 16'h0005;
    rom[1] = 16'h5020; alu_tab[1] = 16'h0000;
    rom[2] = 16'h983F; alu_tab[2] = 16'h8000; waits[2] = 2;
    rom[3] = 16'h0E02;
    rom[4] = 16'h1261; alu_tab[4] = 16'h7FFF; waits[4] = 3;
    rom[5] = 16'h5020; alu_tab[5] = 16'hFFFF; waits[5] = 1;
    rom[6] = 16'h1261; alu_tab[6] = 16'h0001; waits[6] = 6;
  end

  always_comb begin
    mem_rdata = rom[mem_addr[3:0]];
    mem_ready = (mem_rd && (wcnt >= waits[mem_addr[3:0]])) || force_ready;
    prev_pc   = pc - 16'd1;
    alu_out   = alu_tab[prev_pc[3:0]];
  end

  always @(posedge clk) begin
    if (!reset_n || !mem_rd || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always_comb begin
    mem_rdata_w = 16'h1261;
    mem_ready_w = mem_rd_w;
    alu_out_w   = 16'h0001;
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  function automatic logic is_legal(input logic [15:0] instr);
    return (instr[15:12] == 4'd1) || (instr[15:12] == 4'd5) || (instr[15:12] == 4'd9);
  endfunction

  function automatic logic [1:0] exp_ctl(input logic [15:0] instr);
    if (instr[15:12] == 4'd1) return 2'b01;
    if (instr[15:12] == 4'd5) return 2'b10;
    if (instr[15:12] == 4'd9) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_nzp(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0) return 3'b010;
    return 3'b001;
  endfunction

  logic        rst_seen = 1'b0;
  logic        started  = 1'b0;
  logic [15:0] m_pc = 16'h3000, m_cnt = 16'h0, m_ir = 16'h0, m_addr = 16'h0;
  logic [2:0]  m_nzp = 3'b010;
  logic        m_ill = 1'b0;
  int          m_phase = 0;  // 0: between instructions, 1: decode due, 2: write-back due

  always @(posedge clk) rst_seen <= !reset_n;

  task automatic chk_fields();
    chk("dr_sel", 16'(dr_sel), 16'(m_ir[11:9]));
    chk("sr1_sel", 16'(sr1_sel), 16'(m_ir[8:6]));
    chk("sr2_sel", 16'(sr2_sel), 16'(m_ir[2:0]));
    chk("alu_imm", 16'(alu_imm), 16'(m_ir[5:0]));
    chk("alu_control", 16'(alu_control), 16'(exp_ctl(m_ir)));
  endtask

  always @(negedge clk) begin
    if (rst_seen) begin
      started = 1'b1;
      m_pc = 16'h3000; m_cnt = 16'h0; m_nzp = 3'b010; m_ill = 1'b0; m_phase = 0;
      chk("rst_mem_rd", 16'(mem_rd), 16'd0);
      chk("rst_reg_we", 16'(reg_we), 16'd0);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_pc", pc, m_pc);
    end else if (started) begin
      chk("m_pc", pc, m_pc);
      chk("m_count", instr_count, m_cnt);
      chk("m_nzp", 16'(nzp), 16'(m_nzp));
      chk("m_illegal", 16'(illegal), 16'(m_ill));
      if (mem_rd) chk("m_mem_addr", mem_addr, m_pc);
      if (m_phase == 1) begin
        chk("m_dec_mem_rd", 16'(mem_rd), 16'd0);
        chk("m_dec_reg_we", 16'(reg_we), 16'd0);
        chk("m_ir", ir, m_ir);
        chk_fields();
        if (is_legal(m_ir)) m_phase = 2;
        else begin
          m_ill = 1'b1;
          m_phase = 0;
        end
      end else if (m_phase == 2) begin
        chk("m_exe_reg_we", 16'(reg_we), 16'd1);
        chk("m_exe_mem_rd", 16'(mem_rd), 16'd0);
        chk_fields();
        m_nzp = exp_nzp(alu_tab[m_addr[3:0]]);
        m_cnt = m_cnt + 16'd1;
        m_phase = 0;
      end else begin
        chk("m_reg_we", 16'(reg_we), 16'd0);
        if (mem_rd && mem_ready) begin
          m_addr = m_pc;
          m_ir = rom[m_pc[3:0]];
          m_pc = m_pc + 16'd1;
          m_phase = 1;
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; run_w = 1'b0;
    tick(2);
    chk("reset_pc", pc, 16'h3000);
    chk("reset_nzp", 16'(nzp), 16'h0002);
    chk("reset_count", instr_count, 16'h0000);
    chk("reset_illegal", 16'(illegal), 16'h0000);
    chk("reset_mem_rd", 16'(mem_rd), 16'h0000);
    reset_n = 1'b1;
    tick(1);
    chk("idle_mem_rd", 16'(mem_rd), 16'h0000);

    // ADD R1,R1,#1 zero wait, result 5
    run = 1'b1;
    tick(1);
    chk("add_fetch_rd", 16'(mem_rd), 16'h0001);
    chk("add_fetch_addr", mem_addr, 16'h3000);
    tick(1);
    chk("add_dec_ir", ir, 16'h1261);
    chk("add_dec_we", 16'(reg_we), 16'h0000);
    tick(1);
    chk("add_exe_we", 16'(reg_we), 16'h0001);
    chk("add_dr", 16'(dr_sel), 16'h0001);
    chk("add_sr1", 16'(sr1_sel), 16'h0001);
    chk("add_ctl", 16'(alu_control), 16'h0001);
    chk("add_imm", 16'(alu_imm), 16'h0021);
    tick(1);
    chk("add_nzp", 16'(nzp), 16'h0001);
    chk("add_pc", pc, 16'h3001);
    chk("add_count", instr_count, 16'h0001);

    // AND R0,R0,#0 result 0
    tick(2);
    chk("and_exe_we", 16'(reg_we), 16'h0001);
    chk("and_ctl", 16'(alu_control), 16'h0002);
    tick(1);
    chk("and_nzp", 16'(nzp), 16'h0002);

    // NOT with two wait states, result 8000
    chk("not_rd0", 16'(mem_rd), 16'h0001);
    tick(1);
    chk("not_rd1", 16'(mem_rd), 16'h0001);
    tick(1);
    chk("not_rd2", 16'(mem_rd), 16'h0001);
    chk("not_ready", 16'(mem_ready), 16'h0001);
    tick(1);
    chk("not_dec_rd", 16'(mem_rd), 16'h0000);
    tick(1);
    chk("not_exe_we", 16'(reg_we), 16'h0001);
    chk("not_ctl", 16'(alu_control), 16'h0003);
    tick(1);
    chk("not_nzp", 16'(nzp), 16'h0004);
    chk("not_count", instr_count, 16'h0003);

    // BR: illegal, no write-back
    tick(1);
    chk("br_dec_illegal", 16'(illegal), 16'h0000);
    chk("br_dec_we", 16'(reg_we), 16'h0000);
    tick(1);
    chk("br_illegal", 16'(illegal), 16'h0001);
    chk("br_we", 16'(reg_we), 16'h0000);
    chk("br_nzp", 16'(nzp), 16'h0004);
    chk("br_count", instr_count, 16'h0003);
    chk("br_next_addr", mem_addr, 16'h3004);

    // run dropped during a three-wait fetch
    tick(1);
    run = 1'b0;
    tick(2);
    chk("drop_rd", 16'(mem_rd), 16'h0001);
    tick(2);
    chk("drop_exe_we", 16'(reg_we), 16'h0001);
    tick(1);
    chk("drop_idle_rd", 16'(mem_rd), 16'h0000);
    chk("drop_count", instr_count, 16'h0004);
    chk("drop_nzp", 16'(nzp), 16'h0001);
    tick(2);
    chk("drop_still_idle", 16'(mem_rd), 16'h0000);

    // one more instruction, then reset during a long fetch wait
    run = 1'b1;
    tick(5);
    chk("neg_count", instr_count, 16'h0005);
    chk("neg_nzp", 16'(nzp), 16'h0004);
    tick(2);
    chk("wait_rd", 16'(mem_rd), 16'h0001);
    reset_n = 1'b0; run = 1'b0;
    tick(1);
    chk("midrst_rd", 16'(mem_rd), 16'h0000);
    chk("midrst_pc", pc, 16'h3000);
    chk("midrst_count", instr_count, 16'h0000);
    chk("midrst_illegal", 16'(illegal), 16'h0000);
    chk("midrst_nzp", 16'(nzp), 16'h0002);

    // stray mem_ready in IDLE is ignored
    reset_n = 1'b1; force_ready = 1'b1;
    tick(2);
    chk("stray_pc", pc, 16'h3000);
    chk("stray_ir", ir, 16'h0000);
    chk("stray_rd", 16'(mem_rd), 16'h0000);
    force_ready = 1'b0;

    // pc wrap on the FFFF instance
    run_w = 1'b1;
    tick(1);
    chk("wrap_addr", mem_addr_w, 16'hFFFF);
    tick(1);
    chk("wrap_pc", pc_w, 16'h0000);
    chk("wrap_ir", ir_w, 16'h1261);
    tick(2);
    chk("wrap_next_rd", 16'(mem_rd_w), 16'h0001);
    chk("wrap_next_addr", mem_addr_w, 16'h0000);
    run_w = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
